// File: rtl/ctrl_sequencer_if.sv
// rtl/ctrl_sequencer_if.sv - control/status bundle between a sequencer and its host
interface ctrl_sequencer_if #(
    parameter int STEPS = 4,
    parameter int CW    = 2,
    parameter int SW    = 4
);
    logic                  start;
    logic                  mode;
    logic                  hold;
    logic                  abort;
    logic [STEPS*CW-1:0]   ctrl_table;
    logic [CW-1:0]         ctrl_out;
    logic [SW-1:0]         step;
    logic                  busy;
    logic                  done;

    // Host side: issues commands and the control table, observes progress
    modport master (
        output start, mode, hold, abort, ctrl_table,
        input  ctrl_out, step, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, mode, hold, abort, ctrl_table,
        output ctrl_out, step, busy, done
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - step sequencer emitting one table-driven control word per cycle
module ctrl_sequencer #(
    parameter int STEPS = 4,
    parameter int CW    = 2,
    parameter int SW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    ctrl_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SW:0]   STEPS_W  = (SW+1)'(STEPS);
    localparam logic [SW-1:0] LAST_IDX = SW'(STEPS-1);

    state_t         state_q;
    logic [SW-1:0]  step_q;
    logic [CW-1:0]  ctrl_q;
    logic           busy_q;
    logic           done_q;

    logic [SW-1:0]  first_idx_d;
    logic [CW-1:0]  first_word_d;
    logic [CW-1:0]  next_word_d;

    // Table lookup that only ever touches entries 0..STEPS-1; anything else reads as zero
    function automatic logic [CW-1:0] pick(input logic [STEPS*CW-1:0] tbl,
                                           input logic [SW-1:0]       idx);
        logic [CW-1:0] w;
        w = '0;
        for (int i = 0; i < STEPS; i++) begin
            if (idx == SW'(i)) begin
                w = tbl[i*CW +: CW];
            end
        end
        return w;
    endfunction

    // Control words for the entry step and for the step after the current one
    always_comb begin
        first_idx_d  = bus.mode ? SW'(1) : '0;
        first_word_d = pick(bus.ctrl_table, first_idx_d);
        next_word_d  = pick(bus.ctrl_table, step_q + SW'(1));
    end

    // Sequencer FSM with registered Moore outputs; any illegal state/step falls back to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        step_q  <= first_idx_d;
                        ctrl_q  <= first_word_d;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        step_q  <= '0;
                        ctrl_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (({1'b0, step_q} >= STEPS_W) || bus.abort) begin
                        state_q <= S_IDLE;
                        step_q  <= '0;
                        ctrl_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (bus.hold) begin
                        state_q <= S_RUN;
                    end else if (step_q == LAST_IDX) begin
                        state_q <= S_DONE;
                        step_q  <= '0;
                        ctrl_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                        step_q  <= step_q + SW'(1);
                        ctrl_q  <= next_word_d;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    step_q  <= '0;
                    ctrl_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    step_q  <= '0;
                    ctrl_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ctrl_out = ctrl_q;
    assign bus.step     = step_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - self-checking bench for ctrl_sequencer
module tb_ctrl_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_sequencer_if #(.STEPS(4), .CW(2), .SW(4)) b0 ();
    ctrl_sequencer_if #(.STEPS(8), .CW(4), .SW(4)) b1 ();

    ctrl_sequencer #(.STEPS(4), .CW(2), .SW(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    ctrl_sequencer #(.STEPS(8), .CW(4), .SW(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        bit       start;
        bit       mode;
        bit       hold;
        bit       abort;
        bit [1:0] ec;
        bit [3:0] es;
        bit       eb;
        bit       ed;
    } vec_t;

    vec_t vq[$];
    int   mq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] pk(input logic [3:0] c, input logic [3:0] s,
                                       input logic b, input logic d);
        return 32'({c, s, b, d});
    endfunction

    function automatic logic [31:0] obs0();
        return pk({2'b00, b0.ctrl_out}, b0.step, b0.busy, b0.done);
    endfunction

    function automatic logic [31:0] obs1();
        return pk(b1.ctrl_out, b1.step, b1.busy, b1.done);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit st, input bit md, input bit hd, input bit ab,
                       input bit [1:0] c, input bit [3:0] s, input bit b, input bit d);
        vec_t v;
        v.start = st; v.mode = md; v.hold = hd; v.abort = ab;
        v.ec = c; v.es = s; v.eb = b; v.ed = d;
        vq.push_back(v);
    endtask

    // Queue model: pending step indices, -1 marks the completion cycle, empty means idle
    task automatic model_edge(input bit st, input bit md, input bit hd, input bit ab);
        if (mq.size() == 0) begin
            if (st) begin
                for (int s = (md ? 1 : 0); s < 4; s++) mq.push_back(s);
                mq.push_back(-1);
            end
        end else if (mq[0] == -1) begin
            void'(mq.pop_front());
        end else if (ab) begin
            mq.delete();
        end else if (!hd) begin
            void'(mq.pop_front());
        end
    endtask

    function automatic logic [31:0] model_exp(input logic [7:0] tbl);
        logic [7:0] sh;
        if (mq.size() == 0) return pk(4'd0, 4'd0, 1'b0, 1'b0);
        if (mq[0] == -1)    return pk(4'd0, 4'd0, 1'b0, 1'b1);
        sh = tbl >> (2 * mq[0]);
        return pk({2'b00, sh[1:0]}, 4'(mq[0]), 1'b1, 1'b0);
    endfunction

    initial begin
        int n;
        logic [7:0] rtbl;
        logic [3:0] w;

        b0.start = 0; b0.mode = 0; b0.hold = 0; b0.abort = 0;
        b0.ctrl_table = {2'b10, 2'b11, 2'b01, 2'b00};
        b1.start = 0; b1.mode = 0; b1.hold = 0; b1.abort = 0;
        for (int i = 0; i < 8; i++) b1.ctrl_table[i*4 +: 4] = 4'(i + 1);

        #12;
        check("reset_d0", obs0(), pk(4'd0, 4'd0, 1'b0, 1'b0));
        check("reset_d1", obs1(), pk(4'd0, 4'd0, 1'b0, 1'b0));
        @(posedge clk); #1; rst = 0;

        // normal path
        add(1,0,0,0, 2'd0, 4'd0, 1, 0);
        add(0,0,0,0, 2'd1, 4'd1, 1, 0);
        add(0,0,0,0, 2'd3, 4'd2, 1, 0);
        add(0,0,0,0, 2'd2, 4'd3, 1, 0);
        add(0,0,0,0, 2'd0, 4'd0, 0, 1);
        add(0,0,0,0, 2'd0, 4'd0, 0, 0);
        // short path
        add(1,1,0,0, 2'd1, 4'd1, 1, 0);
        add(0,0,0,0, 2'd3, 4'd2, 1, 0);
        add(0,0,0,0, 2'd2, 4'd3, 1, 0);
        add(0,0,0,0, 2'd0, 4'd0, 0, 1);
        add(0,0,0,0, 2'd0, 4'd0, 0, 0);
        // hold at step 2 for three cycles
        add(1,0,0,0, 2'd0, 4'd0, 1, 0);
        add(0,0,0,0, 2'd1, 4'd1, 1, 0);
        add(0,0,0,0, 2'd3, 4'd2, 1, 0);
        add(0,0,1,0, 2'd3, 4'd2, 1, 0);
        add(0,0,1,0, 2'd3, 4'd2, 1, 0);
        add(0,0,1,0, 2'd3, 4'd2, 1, 0);
        add(0,0,0,0, 2'd2, 4'd3, 1, 0);
        add(0,0,0,0, 2'd0, 4'd0, 0, 1);
        add(0,0,0,0, 2'd0, 4'd0, 0, 0);
        // start ignored at step 1, abort (with hold) at step 2
        add(1,0,0,0, 2'd0, 4'd0, 1, 0);
        add(0,0,0,0, 2'd1, 4'd1, 1, 0);
        add(1,0,0,0, 2'd3, 4'd2, 1, 0);
        add(0,0,1,1, 2'd0, 4'd0, 0, 0);
        add(0,0,0,0, 2'd0, 4'd0, 0, 0);
        // hold/abort ignored in IDLE, start in DONE ignored
        add(0,0,1,1, 2'd0, 4'd0, 0, 0);
        add(1,0,0,1, 2'd0, 4'd0, 1, 0);
        add(0,0,0,0, 2'd1, 4'd1, 1, 0);
        add(0,0,0,0, 2'd3, 4'd2, 1, 0);
        add(0,0,0,0, 2'd2, 4'd3, 1, 0);
        add(1,0,0,0, 2'd0, 4'd0, 0, 1);
        add(1,0,1,1, 2'd0, 4'd0, 0, 0);
        add(0,0,0,0, 2'd0, 4'd0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            b0.start = vq[i].start; b0.mode = vq[i].mode;
            b0.hold  = vq[i].hold;  b0.abort = vq[i].abort;
            tick();
            check($sformatf("vec%0d", i), obs0(),
                  pk({2'b00, vq[i].ec}, vq[i].es, vq[i].eb, vq[i].ed));
        end
        b0.start = 0; b0.mode = 0; b0.hold = 0; b0.abort = 0;

        // reset asserted between edges at step 1
        b0.start = 1; tick(); b0.start = 0;
        tick();
        check("rst_pre", obs0(), pk(4'd1, 4'd1, 1'b1, 1'b0));
        #2 rst = 1; #1;
        check("rst_async", obs0(), pk(4'd0, 4'd0, 1'b0, 1'b0));
        tick(); rst = 0;
        b0.start = 1; tick(); b0.start = 0;
        check("rst_seq0", obs0(), pk(4'd0, 4'd0, 1'b1, 1'b0));
        tick(); check("rst_seq1", obs0(), pk(4'd1, 4'd1, 1'b1, 1'b0));
        tick(); check("rst_seq2", obs0(), pk(4'd3, 4'd2, 1'b1, 1'b0));
        tick(); check("rst_seq3", obs0(), pk(4'd2, 4'd3, 1'b1, 1'b0));
        tick(); check("rst_done", obs0(), pk(4'd0, 4'd0, 1'b0, 1'b1));
        tick(); check("rst_idle", obs0(), pk(4'd0, 4'd0, 1'b0, 1'b0));

        // 8-step, 4-bit variant: full and short path
        b1.start = 1; b1.mode = 0; tick(); b1.start = 0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("p8_full%0d", k), obs1(), pk(4'(k + 1), 4'(k), 1'b1, 1'b0));
            tick();
        end
        check("p8_full_done", obs1(), pk(4'd0, 4'd0, 1'b0, 1'b1));
        tick();
        b1.start = 1; b1.mode = 1; tick(); b1.start = 0; b1.mode = 0;
        for (int k = 1; k < 8; k++) begin
            check($sformatf("p8_short%0d", k), obs1(), pk(4'(k + 1), 4'(k), 1'b1, 1'b0));
            tick();
        end
        check("p8_short_done", obs1(), pk(4'd0, 4'd0, 1'b0, 1'b1));
        tick();

        // sequence length with two held cycles, bounded wait for done
        b1.start = 1; tick(); b1.start = 0;
        n = 1;
        while (!b1.done && n < 40) begin
            b1.hold = (n == 3 || n == 4);
            tick();
            n++;
        end
        b1.hold = 0;
        check("p8_len_hold", 32'(n), 32'd11);
        tick();

        // randomized run against the queue model
        rtbl = 8'($urandom);
        b0.ctrl_table = rtbl;
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            b0.start = ($urandom_range(0, 3) == 0);
            b0.mode  = 1'($urandom_range(0, 1));
            b0.hold  = ($urandom_range(0, 4) == 0);
            b0.abort = ($urandom_range(0, 19) == 0);
            model_edge(b0.start, b0.mode, b0.hold, b0.abort);
            tick();
            check($sformatf("rnd%0d", c), obs0(), model_exp(rtbl));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1; #1;
                mq.delete();
                check($sformatf("rnd_rst%0d", c), obs0(), model_exp(rtbl));
                rst = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 4, meaning number of sequence steps (legal 2..16).
REQ-002 SHALL have parameter CW, default 2, meaning control-word width per step (legal 1..8).
REQ-003 SHALL have parameter SW, default 4, meaning step-index width (2^SW >= STEPS).
REQ-004 SHALL have port clk  input  1  meaning clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  meaning request to begin a sequence; sampled only in IDLE.
REQ-007 SHALL have port mode  input  1  meaning short-path select, sampled with start (1 = skip step 0).
REQ-008 SHALL have port hold  input  1  meaning freeze at the current step while in RUN.
REQ-009 SHALL have port abort  input  1  meaning terminate the sequence and return to IDLE without done.
REQ-010 SHALL have port ctrl_table  input  STEPS*CW  meaning control word for step i at bits [i*CW +: CW].
REQ-011 SHALL have port ctrl_out  output  CW  meaning active control word.
REQ-012 SHALL have port step  output  SW  meaning current step index.
REQ-013 SHALL have port busy  output  1  meaning high while in RUN.
REQ-014 SHALL have port done  output  1  meaning one-cycle completion pulse.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, RUN, DONE; outputs are decoded from registered state and step only.
REQ-016 SHALL drive, in IDLE: ctrl_out=0, busy=0, done=0, step=0.
REQ-017 SHALL, in IDLE with start=1 at an edge, enter RUN with step=1 if mode=1, else step=0.
REQ-018 SHALL, in RUN, drive busy=1, done=0 and ctrl_out=ctrl_table[step*CW +: CW], so the first control word appears in the cycle after the start edge.
REQ-019 SHALL, in RUN with abort=0 and hold=0, increment step each edge while step<STEPS-1, and enter DONE on the edge where step==STEPS-1.
REQ-020 SHALL, in RUN with hold=1 and abort=0, keep state, step and ctrl_out unchanged.
REQ-021 SHALL, in RUN with abort=1, enter IDLE on the next edge with done never asserted; abort takes priority over hold.
REQ-022 SHALL, in DONE, drive done=1, busy=0, ctrl_out=0, step=0, and enter IDLE on the next edge unconditionally.
REQ-023 SHALL ignore start while in RUN or DONE; no queued restart occurs.
REQ-024 SHALL ignore hold and abort in IDLE and DONE.
REQ-025 SHALL not read ctrl_table entries at indices >= STEPS.
REQ-026 SHALL enter IDLE on the next edge from any unencoded state or any step>=STEPS; no lock-up or out-of-range state is permitted.
REQ-027 SHALL have a sequence length, start edge to done pulse, of STEPS+1 cycles with mode=0 and STEPS cycles with mode=1, plus one cycle per held cycle.

Reset
REQ-028 SHALL, while rst=1, immediately force IDLE, step=0, ctrl_out=0, busy=0 and done=0, independent of clk.
REQ-029 SHALL, on reset asserted mid-RUN, discard the sequence with no done pulse; after release, the next start begins a fresh sequence.

Verification
REQ-030 SHALL cover normal path: defaults, table step0..3 = 00,01,11,10, mode=0, pulse start -> ctrl_out 00,01,11,10 on 4 consecutive cycles with busy=1, then done=1 for 1 cycle with ctrl_out=00.
REQ-031 SHALL cover short path: same table, mode=1, pulse start -> ctrl_out 01,11,10, then done pulse; step shows 1,2,3.
REQ-032 SHALL cover hold: hold=1 for 3 cycles while step=2 -> ctrl_out stays 11 for 4 cycles total; done arrives 3 cycles later than in REQ-030.
REQ-033 SHALL cover abort and start-ignore: start pulsed again at step=1 -> no effect; abort=1 at step=2 -> IDLE next cycle, ctrl_out=00, done never asserted.
REQ-034 SHALL cover reset mid-operation: rst=1 asserted between edges at step=1 -> outputs 0 before the next edge; after release, start with mode=0 -> full 00,01,11,10 sequence.
REQ-035 SHALL cover the parameter variant STEPS=8, CW=4, table entry i = i+1 -> ctrl_out 1..8 on 8 cycles, then done; with mode=1 -> ctrl_out 2..8.
